// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with register file, load-use stall, flush squash and ID/EX register.
// Define ID_WB_BYPASS_EN to forward a same-cycle writeback to the register-file reads.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pcplus4,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  output logic        stall_out,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4,
  output logic [31:0] id_instr,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic [31:0] id_imm,
  output logic        id_regwrite,
  output logic        id_memread,
  output logic        id_memwrite,
  output logic        id_branch,
  output logic        id_jump,
  output logic        id_alusrc,
  output logic        id_illegal
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                         OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] NOP = 32'h00000013;
  logic [31:0] r_pc_q, r_pcplus4_q;
  logic        r_squash_q;
  logic [31:0] r_rf [32];
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
  logic        w_regwrite, w_memread, w_memwrite, w_branch, w_jump, w_alusrc, w_illegal;
  logic        w_use_rs1, w_use_rs2, w_has_rd, w_bubble;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_rf1, w_rf2, w_rs1_data, w_rs2_data;
  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_u = {instr[31:12], 12'b0};
  assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  always_comb begin
    w_imm      = '0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    w_alusrc   = 1'b0;
    w_illegal  = 1'b0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_has_rd   = 1'b0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: begin w_imm = w_imm_u; w_regwrite = 1'b1; w_alusrc = 1'b1; w_has_rd = 1'b1; end
      OP_JAL:    begin w_imm = w_imm_j; w_regwrite = 1'b1; w_jump = 1'b1; w_has_rd = 1'b1; end
      OP_JALR:   begin w_imm = w_imm_i; w_regwrite = 1'b1; w_jump = 1'b1; w_alusrc = 1'b1; w_has_rd = 1'b1; w_use_rs1 = 1'b1; end
      OP_BRANCH: begin w_imm = w_imm_b; w_branch = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_LOAD:   begin w_imm = w_imm_i; w_regwrite = 1'b1; w_memread = 1'b1; w_alusrc = 1'b1; w_has_rd = 1'b1; w_use_rs1 = 1'b1; end
      OP_STORE:  begin w_imm = w_imm_s; w_memwrite = 1'b1; w_alusrc = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_IMM:    begin w_imm = w_imm_i; w_regwrite = 1'b1; w_alusrc = 1'b1; w_has_rd = 1'b1; w_use_rs1 = 1'b1; end
      OP_REG:    begin w_regwrite = 1'b1; w_has_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OP_FENCE, OP_SYSTEM: w_imm = w_imm_i;
      default:   w_illegal = 1'b1;
    endcase
  end
  // Unused register fields read as x0 so they can never match a load destination.
  assign w_rs1 = w_use_rs1 ? instr[19:15] : 5'd0;
  assign w_rs2 = w_use_rs2 ? instr[24:20] : 5'd0;
  assign w_rd  = w_has_rd ? instr[11:7] : 5'd0;
  assign stall_out = !flush && !r_squash_q && ex_memread && ex_rd != 5'd0 &&
                     (w_rs1 == ex_rd || w_rs2 == ex_rd);
  assign w_bubble = flush || r_squash_q || stall_out;
  assign w_rf1 = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_rf2 = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];
`ifdef ID_WB_BYPASS_EN
  assign w_rs1_data = (wb_we && wb_rd != 5'd0 && wb_rd == w_rs1) ? wb_data : w_rf1;
  assign w_rs2_data = (wb_we && wb_rd != 5'd0 && wb_rd == w_rs2) ? wb_data : w_rf2;
`else
  assign w_rs1_data = w_rf1;
  assign w_rs2_data = w_rf2;
`endif
  always_ff @(posedge clk)
    if (wb_we && wb_rd != 5'd0) r_rf[wb_rd] <= wb_data;
  // Reset leaves squash set so the first BRAM word after reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_q      <= '0;
      r_pcplus4_q <= '0;
      r_squash_q  <= 1'b1;
    end else begin
      r_squash_q <= flush;
      if (!stall_out) begin
        r_pc_q      <= if_pc;
        r_pcplus4_q <= if_pcplus4;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_pcplus4  <= '0;
      id_instr    <= NOP;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      id_regwrite <= 1'b0;
      id_memread  <= 1'b0;
      id_memwrite <= 1'b0;
      id_branch   <= 1'b0;
      id_jump     <= 1'b0;
      id_alusrc   <= 1'b0;
      id_illegal  <= 1'b0;
    end else begin
      id_valid    <= 1'b1;
      id_pc       <= r_pc_q;
      id_pcplus4  <= r_pcplus4_q;
      id_instr    <= instr;
      id_rs1      <= w_rs1;
      id_rs2      <= w_rs2;
      id_rd       <= w_rd;
      id_rs1_data <= w_rs1_data;
      id_rs2_data <= w_rs2_data;
      id_imm      <= w_imm;
      id_regwrite <= w_regwrite;
      id_memread  <= w_memread;
      id_memwrite <= w_memwrite;
      id_branch   <= w_branch;
      id_jump     <= w_jump;
      id_alusrc   <= w_alusrc;
      id_illegal  <= w_illegal;
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector table plus hand-written stall, flush, reset and writeback sequences.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, wb_we, ex_memread;
  logic [31:0] instr, if_pc, if_pcplus4, wb_data;
  logic [4:0]  wb_rd, ex_rd;
  logic        stall_out, id_valid;
  logic [31:0] id_pc, id_pcplus4, id_instr, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regwrite, id_memread, id_memwrite, id_branch, id_jump, id_alusrc, id_illegal;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  id_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .instr(instr), .if_pc(if_pc), .if_pcplus4(if_pcplus4),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .stall_out(stall_out), .id_valid(id_valid), .id_pc(id_pc), .id_pcplus4(id_pcplus4),
    .id_instr(id_instr), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_jump(id_jump), .id_alusrc(id_alusrc), .id_illegal(id_illegal)
  );
  typedef struct {
    logic [31:0] instr;
    logic        exm;
    logic [4:0]  exrd;
    logic        stall;
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  ctl;
  } vec_t;
  vec_t tbl [18];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [6:0] ctl_now;
    return {id_regwrite, id_memread, id_memwrite, id_branch, id_jump, id_alusrc, id_illegal};
  endfunction
  initial begin
    // ctl = {regwrite, memread, memwrite, branch, jump, alusrc, illegal}
    tbl[0]  = '{32'h00500093, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1, 32'd5,        7'b1000010};
    tbl[1]  = '{32'h123451B7, 1'b0, 5'd0,  1'b0, 1'b1, 5'd3, 32'h12345000, 7'b1000010};
    tbl[2]  = '{32'h0020A423, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0, 32'd8,        7'b0010010};
    tbl[3]  = '{32'hFE000EE3, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0, 32'hFFFFFFFC, 7'b0001000};
    tbl[4]  = '{32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 1'b1, 5'd0, 32'd0,        7'b0000001};
    tbl[5]  = '{32'h010000EF, 1'b0, 5'd0,  1'b0, 1'b1, 5'd1, 32'd16,       7'b1000100};
    tbl[6]  = '{32'hFFC12283, 1'b0, 5'd0,  1'b0, 1'b1, 5'd5, 32'hFFFFFFFC, 7'b1100010};
    tbl[7]  = '{32'h00218233, 1'b0, 5'd0,  1'b0, 1'b1, 5'd4, 32'd0,        7'b1000000};
    tbl[8]  = '{32'h00001317, 1'b0, 5'd0,  1'b0, 1'b1, 5'd6, 32'h00001000, 7'b1000010};
    tbl[9]  = '{32'h00218233, 1'b1, 5'd3,  1'b1, 1'b0, 5'd0, 32'd0,        7'b0000000};
    tbl[10] = '{32'h00218233, 1'b1, 5'd2,  1'b1, 1'b0, 5'd0, 32'd0,        7'b0000000};
    tbl[11] = '{32'h00218233, 1'b0, 5'd3,  1'b0, 1'b1, 5'd4, 32'd0,        7'b1000000};
    tbl[12] = '{32'h123451B7, 1'b1, 5'd3,  1'b0, 1'b1, 5'd3, 32'h12345000, 7'b1000010};
    tbl[13] = '{32'h123451B7, 1'b1, 5'd10, 1'b0, 1'b1, 5'd3, 32'h12345000, 7'b1000010};
    tbl[14] = '{32'h00500093, 1'b1, 5'd0,  1'b0, 1'b1, 5'd1, 32'd5,        7'b1000010};
    tbl[15] = '{32'hFFFFFFFF, 1'b1, 5'd31, 1'b0, 1'b1, 5'd0, 32'd0,        7'b0000001};
    tbl[16] = '{32'h010000EF, 1'b1, 5'd1,  1'b0, 1'b1, 5'd1, 32'd16,       7'b1000100};
    tbl[17] = '{32'h0020A423, 1'b1, 5'd1,  1'b1, 1'b0, 5'd0, 32'd0,        7'b0000000};
    rst_n = 1'b0; flush = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
    ex_memread = 1'b1; ex_rd = 5'd3; instr = 32'h00218233; if_pc = 32'h100; if_pcplus4 = 32'h104;
    step;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'h00000013);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_imm", id_imm, 32'd0);
    chk("rst_ctl", {25'd0, ctl_now()}, 32'd0);
    flush = 1'b0;
    #1;
    chk("squash_no_stall", {31'd0, stall_out}, 32'd0);
    rst_n = 1'b1;
    step;
    chk("post_rst_bubble", {31'd0, id_valid}, 32'd0);
    ex_memread = 1'b0; ex_rd = 5'd0;
    for (int i = 0; i < 18; i++) begin
      instr = tbl[i].instr; ex_memread = tbl[i].exm; ex_rd = tbl[i].exrd;
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall_out}, {31'd0, tbl[i].stall});
      step;
      chk($sformatf("v%0d_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].valid});
      chk($sformatf("v%0d_rd", i), {27'd0, id_rd}, {27'd0, tbl[i].rd});
      chk($sformatf("v%0d_imm", i), id_imm, tbl[i].imm);
      chk($sformatf("v%0d_ctl", i), {25'd0, ctl_now()}, {25'd0, tbl[i].ctl});
      chk($sformatf("v%0d_instr", i), id_instr, tbl[i].valid ? tbl[i].instr : 32'h00000013);
    end
    ex_memread = 1'b0; ex_rd = 5'd0;
    if_pc = 32'h200; if_pcplus4 = 32'h204; instr = 32'h00500093;
    step;
    if_pc = 32'h204; if_pcplus4 = 32'h208; instr = 32'h00218233; ex_memread = 1'b1; ex_rd = 5'd3;
    #1;
    chk("lu_stall", {31'd0, stall_out}, 32'd1);
    step;
    chk("lu_bubble", {31'd0, id_valid}, 32'd0);
    ex_memread = 1'b0; if_pc = 32'h208; if_pcplus4 = 32'h20C;
    step;
    chk("lu_valid", {31'd0, id_valid}, 32'd1);
    chk("lu_pc_held", id_pc, 32'h200);
    chk("lu_pc4_held", id_pcplus4, 32'h204);
    flush = 1'b1; ex_memread = 1'b1; ex_rd = 5'd3;
    #1;
    chk("fl_no_stall", {31'd0, stall_out}, 32'd0);
    step;
    chk("fl_b1_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_b1_instr", id_instr, 32'h00000013);
    chk("fl_b1_rd", {27'd0, id_rd}, 32'd0);
    flush = 1'b0;
    #1;
    chk("sq_no_stall", {31'd0, stall_out}, 32'd0);
    step;
    chk("fl_b2_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_b2_instr", id_instr, 32'h00000013);
    ex_memread = 1'b0; ex_rd = 5'd0; instr = 32'h00500093;
    step;
    chk("fl_third_valid", {31'd0, id_valid}, 32'd1);
    chk("fl_third_instr", id_instr, 32'h00500093);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h11111111; instr = 32'h00000013;
    step;
    wb_data = 32'hDEADBEEF; instr = 32'h00038413;
    step;
`ifdef ID_WB_BYPASS_EN
    chk("wb_same_cycle", id_rs1_data, 32'hDEADBEEF);
`else
    chk("wb_same_cycle", id_rs1_data, 32'h11111111);
`endif
    chk("wb_rs1_idx", {27'd0, id_rs1}, 32'd7);
    wb_we = 1'b0;
    step;
    chk("wb_after", id_rs1_data, 32'hDEADBEEF);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF; instr = 32'h00500093;
    step;
    chk("x0_same_cycle", id_rs1_data, 32'd0);
    wb_we = 1'b0;
    step;
    chk("x0_after", id_rs1_data, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port flush, input, 1, redirect taken in EX (same signal as IF pcsrc).
REQ-004 SHALL have port instr, input, 32, instruction-memory read data (registered BRAM output, valid one cycle after its PC).
REQ-005 SHALL have ports if_pc and if_pcplus4, input, 32 each, fetch PC fields of the IF/ID bundle.
REQ-006 SHALL have ports wb_we (1), wb_rd (5) and wb_data (32), all inputs, writeback port.
REQ-007 SHALL have ports ex_memread (1) and ex_rd (5), inputs, load in EX for hazard detection.
REQ-008 SHALL have port stall_out, output, 1, combinational, drives IF stall.
REQ-009 SHALL have registered ID/EX outputs: id_valid 1, id_pc 32, id_pcplus4 32, id_instr 32, id_rs1/id_rs2/id_rd 5 each, id_rs1_data/id_rs2_data 32 each, id_imm 32.
REQ-010 SHALL have registered 1-bit control outputs id_regwrite, id_memread, id_memwrite, id_branch, id_jump, id_alusrc and id_illegal.

Function
REQ-011 SHALL capture if_pc/if_pcplus4 into pc_q/pcplus4_q on each edge with stall_out=0, pairing them with instr on the following cycle.
REQ-012 SHALL decode instr combinationally and load the ID/EX outputs on the next edge: one-cycle latency.
REQ-013 SHALL generate id_imm sign-extended for I, S, B, U and J formats per RV32I; R-type imm SHALL be 0.
REQ-014 SHALL assert id_illegal for any opcode outside RV32I base set; such an instruction SHALL have regwrite, memread, memwrite, branch and jump all 0.
REQ-015 SHALL contain a 32x32 register file with 2 async reads and 1 write; writes to x0 ignored; x0 reads 0.
REQ-016 SHALL assert stall_out when ex_memread=1, ex_rd!=0 and ex_rd matches a source register the decoded format actually uses (rs1 and/or rs2).
REQ-017 While stall_out=1: pc_q held, ID/EX loaded with a bubble (id_valid=0, all control outputs 0).
REQ-018 SHALL, on flush=1, load a bubble into ID/EX and set squash_q so the next cycle's instr is also bubbled.
REQ-019 flush SHALL take priority over load-use: stall_out forced to 0 while flush=1 or squash_q=1.
REQ-020 A bubble SHALL carry id_instr=32'h00000013 (NOP), id_rd=0.
REQ-021 squash_q SHALL clear after one cycle unless flush is reasserted.

Reset
REQ-022 With rst_n=0 at an edge, all ID/EX outputs SHALL become 0 except id_instr=32'h00000013; pc_q and pcplus4_q SHALL become 0.
REQ-023 Reset SHALL set squash_q=1 so the first BRAM output after reset is discarded.
REQ-024 Register-file contents SHALL NOT be reset; reads of unwritten registers other than x0 are undefined.
REQ-025 Reset SHALL override flush and stall asserted in the same cycle.

Configuration
REQ-026 Macro ID_WB_BYPASS_EN defined: a read of register wb_rd (!=0) with wb_we=1 in the same cycle SHALL return wb_data.
REQ-027 ID_WB_BYPASS_EN undefined: that read SHALL return the pre-write register value; other behaviour identical.

Verification
REQ-028 Reset, then instr=addi x1,x0,5 (32'h00500093) -> next cycle id_valid=1, id_rd=1, id_imm=5, id_regwrite=1, id_alusrc=1.
REQ-029 ex_memread=1, ex_rd=3, instr=add x4,x3,x2 -> stall_out=1; next cycle id_valid=0; pc_q unchanged; ex_rd=3 with lui x3 -> stall_out=0.
REQ-030 flush=1 for one cycle -> two consecutive bubbles (id_valid=0) with id_instr=32'h00000013, then third instruction valid.
REQ-031 wb_we=1, wb_rd=7, wb_data=32'hDEADBEEF while instr reads x7 -> id_rs1_data=32'hDEADBEEF with ID_WB_BYPASS_EN, old value without.
REQ-032 wb_we=1, wb_rd=0, wb_data=32'hFFFFFFFF, then read x0 -> id_rs1_data=0.
REQ-033 instr=32'hFFFFFFFF -> id_illegal=1, all control outputs 0; beq with imm -4 -> id_imm=32'hFFFFFFFC, id_branch=1.
